// File: rtl/pll_seq_pkg.sv
// -----------------------------------------------------------------------------
// pll_seq_pkg
//   Shared definitions for the PLL lock sequencer:
//     - state_e    : sequencer state encoding (visible on the debug/CSR port)
//     - out_t      : bundle of the four registered control outputs
//     - DEF_*      : default parameter values
//     - decode_outputs() : control outputs that belong to each state
// -----------------------------------------------------------------------------
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  typedef struct packed {
    logic pll_rst;
    logic sys_rst;
    logic ready;
    logic fault;
  } out_t;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 50000;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_MAX_RETRIES   = 3;
  localparam int unsigned DEF_CNT_W         = 16;

  // Output values held while the sequencer sits in RESET_PLL; also the
  // power-on value of the output registers.
  localparam out_t RESET_OUTPUTS = '{pll_rst: 1'b1, sys_rst: 1'b1,
                                     ready: 1'b0, fault: 1'b0};

  function automatic out_t decode_outputs(input state_e s);
    out_t o;
    o = RESET_OUTPUTS;
    case (s)
      ST_RESET_PLL: o = RESET_OUTPUTS;
      ST_WAIT_LOCK,
      ST_STABLE:    o = '{pll_rst: 1'b0, sys_rst: 1'b1, ready: 1'b0, fault: 1'b0};
      ST_RUN:       o = '{pll_rst: 1'b0, sys_rst: 1'b0, ready: 1'b1, fault: 1'b0};
      ST_FAULT:     o = '{pll_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0, fault: 1'b1};
      // Unused encodings keep everything held in reset.
      default:      o = RESET_OUTPUTS;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop single-bit synchronizer for a level signal that is asynchronous
//   to clk. Both stages reset asynchronously to 0.
//   Ports:
//     clk  in  destination clock
//     rst  in  asynchronous active-high reset
//     d    in  asynchronous input level
//     q    out synchronized level, two clk cycles behind d
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so that both stages
  // sample their inputs from before the edge, forming a real two-stage shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//   Supervises the ADC clock PLL: pulses the PLL reset, waits for lock,
//   qualifies lock stability and only then releases the reset of the logic
//   clocked by the PLL. Lock timeouts cause PLL retries; after MAX_RETRIES
//   failed attempts the block latches FAULT until soft_reset_req or rst.
//   Runs on the PLL reference clock.
//   Ports:
//     refclk          in   reference clock
//     rst             in   asynchronous active-high reset
//     pll_locked      in   PLL lock, asynchronous to refclk
//     soft_reset_req  in   single-cycle request to restart sequencing
//     pll_rst         out  PLL reset, active-high
//     sys_rst         out  reset for PLL-clocked consumers, active-high
//     ready           out  high only in RUN
//     fault           out  high only in FAULT
//     state           out  current state encoding (pll_seq_pkg::state_e)
//     retry_count     out  failed attempts in the current sequence
//     relock_count    out  lock losses seen in RUN, saturating at 255
//   CNT_W must be wide enough to hold the largest of the three cycle counts.
// -----------------------------------------------------------------------------
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state,
  output logic [1:0] retry_count,
  output logic [7:0] relock_count
);

  // Terminal counts: each phase lasts from count 0 up to and including *_LAST.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [1:0]       retry_q, retry_d;
  logic [7:0]       relock_q, relock_d;
  out_t             out_q, out_d;

  logic       lock_s;
  logic [1:0] retry_inc;
  logic [7:0] relock_inc;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  assign retry_inc  = retry_q + 2'd1;
  assign relock_inc = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;

  // ---------------------------------------------------------------------------
  // State register (also holds the counters and the registered outputs)
  // ---------------------------------------------------------------------------
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RESET_PLL;
      counter_q <= '0;
      retry_q   <= '0;
      relock_q  <= '0;
      out_q     <= RESET_OUTPUTS;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      retry_q   <= retry_d;
      relock_q  <= relock_d;
      out_q     <= out_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    retry_d   = retry_q;
    relock_d  = relock_q;

    if (soft_reset_req) begin
      // Overrides every other transition, including a lock loss in RUN,
      // which is therefore not counted as a relock.
      state_d   = ST_RESET_PLL;
      counter_d = '0;
      retry_d   = '0;
    end else begin
      unique case (state_q)
        ST_RESET_PLL: begin
          if (counter_q == RST_LAST) begin
            state_d   = ST_WAIT_LOCK;
            counter_d = '0;
          end else begin
            counter_d = counter_q + CNT_ONE;
          end
        end

        ST_WAIT_LOCK: begin
          // Lock is tested before the timeout so a lock arriving on the
          // timeout cycle still wins.
          if (lock_s) begin
            state_d   = ST_STABLE;
            counter_d = '0;
          end else if (counter_q == TIMEOUT_LAST) begin
            retry_d   = retry_inc;
            state_d   = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_RESET_PLL;
            counter_d = '0;
          end else begin
            counter_d = counter_q + CNT_ONE;
          end
        end

        ST_STABLE: begin
          // Any low cycle discards the qualification so far; the lock timeout
          // restarts but the attempt is not counted as a failure.
          if (!lock_s) begin
            state_d   = ST_WAIT_LOCK;
            counter_d = '0;
          end else if (counter_q == STABLE_LAST) begin
            state_d   = ST_RUN;
            counter_d = '0;
            retry_d   = '0;
          end else begin
            counter_d = counter_q + CNT_ONE;
          end
        end

        ST_RUN: begin
          if (!lock_s) begin
            state_d   = ST_RESET_PLL;
            counter_d = '0;
            relock_d  = relock_inc;
          end
        end

        ST_FAULT: begin
          // Latched: only soft_reset_req or rst leave this state.
          state_d   = ST_FAULT;
        end

        default: begin
          state_d   = ST_RESET_PLL;
          counter_d = '0;
          retry_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: decoded from the next state and registered, so the outputs
  // always match the registered state and sys_rst asserts on the same edge
  // that leaves RUN.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_d = decode_outputs(state_d);
  end

  assign pll_rst      = out_q.pll_rst;
  assign sys_rst      = out_q.sys_rst;
  assign ready        = out_q.ready;
  assign fault        = out_q.fault;
  assign state        = state_q;
  assign retry_count  = retry_q;
  assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//   Directed scenarios plus a randomized phase. A behavioural model tracks the
//   sequencer in terms of "which phase, how long in it" and the compare
//   process checks all DUT outputs against it after every refclk edge.
//   Literal expectations pin the model at key points of each scenario.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

  localparam int RC = 4;   // RST_CYCLES
  localparam int TO = 20;  // LOCK_TIMEOUT
  localparam int SC = 8;   // STABLE_CYCLES
  localparam int MR = 2;   // MAX_RETRIES

  localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FLT = 4;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       pll_rst, sys_rst, ready, fault;
  logic [2:0] state;
  logic [1:0] retry_count;
  logic [7:0] relock_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 refclk = ~refclk;

  pll_lock_sequencer #(
    .RST_CYCLES   (RC),
    .LOCK_TIMEOUT (TO),
    .STABLE_CYCLES(SC),
    .MAX_RETRIES  (MR),
    .CNT_W        (16)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .soft_reset_req(soft_reset_req),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .fault         (fault),
    .state         (state),
    .retry_count   (retry_count),
    .relock_count  (relock_count)
  );

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: phase + cycles spent in it, lock seen two edges late.
  // ---------------------------------------------------------------------------
  int m_phase, m_n, m_retry, m_relock;
  bit m_hist1, m_hist2;  // pll_locked as sampled one and two edges ago

  task automatic model_reset();
    m_phase = P_RST; m_n = 0; m_retry = 0; m_relock = 0;
    m_hist1 = 0; m_hist2 = 0;
  endtask

  task automatic model_step();
    bit seen;
    seen    = m_hist2;
    m_hist2 = m_hist1;
    m_hist1 = pll_locked;
    if (soft_reset_req) begin
      m_phase = P_RST; m_n = 0; m_retry = 0;
    end else if (m_phase == P_RST) begin
      m_n++;
      if (m_n == RC) begin m_phase = P_WAIT; m_n = 0; end
    end else if (m_phase == P_WAIT) begin
      if (seen) begin
        m_phase = P_STAB; m_n = 0;
      end else begin
        m_n++;
        if (m_n == TO) begin
          m_retry++;
          m_phase = (m_retry == MR) ? P_FLT : P_RST;
          m_n = 0;
        end
      end
    end else if (m_phase == P_STAB) begin
      if (!seen) begin
        m_phase = P_WAIT; m_n = 0;
      end else begin
        m_n++;
        if (m_n == SC) begin m_phase = P_RUN; m_n = 0; m_retry = 0; end
      end
    end else if (m_phase == P_RUN) begin
      if (!seen) begin
        m_phase = P_RST; m_n = 0;
        if (m_relock < 255) m_relock++;
      end
    end
  endtask

  function automatic logic [16:0] model_outputs();
    logic m_pll_rst, m_sys_rst, m_ready, m_fault;
    m_pll_rst = (m_phase == P_RST) || (m_phase == P_FLT);
    m_sys_rst = (m_phase != P_RUN);
    m_ready   = (m_phase == P_RUN);
    m_fault   = (m_phase == P_FLT);
    return {3'(m_phase), m_pll_rst, m_sys_rst, m_ready, m_fault,
            2'(m_retry), 8'(m_relock)};
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge refclk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Compare process: every cycle, away from the edge.
  initial begin
    forever begin
      @(posedge refclk);
      #2;
      check("model {state,pll_rst,sys_rst,ready,fault,retry,relock}",
            32'({state, pll_rst, sys_rst, ready, fault, retry_count, relock_count}),
            32'(model_outputs()));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 4 time units after the edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge refclk);
    #4;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic apply_reset();
    rst = 1'b1; pll_locked = 1'b0; soft_reset_req = 1'b0;
    ticks(2);
    rst = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int k = 0;
    while (state !== s && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(state), 32'(s));
  endtask

  // Counts cycles pll_rst stays high, starting from the current sample.
  task automatic pulse_len(output int c);
    c = 0;
    while (pll_rst === 1'b1 && c < 50) begin
      c++;
      tick();
    end
  endtask

  int plen;

  initial begin
    rst = 1'b0; pll_locked = 1'b0; soft_reset_req = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset state",   32'(state), 0);
    check("reset pll_rst", 32'(pll_rst), 1);
    check("reset sys_rst", 32'(sys_rst), 1);
    check("reset ready",   32'(ready), 0);
    check("reset fault",   32'(fault), 0);
    check("reset retry",   32'(retry_count), 0);
    check("reset relock",  32'(relock_count), 0);

    // Clean lock: pll_locked rises before the 10th edge after release.
    ticks(1);
    rst = 1'b0;
    ticks(3);
    check("clean pll_rst still high after 3", 32'(pll_rst), 1);
    tick();
    check("clean pll_rst low after 4", 32'(pll_rst), 0);
    check("clean wait_lock", 32'(state), 1);
    ticks(5);
    pll_locked = 1'b1;
    ticks(10);
    check("clean not ready yet", 32'(ready), 0);
    tick();
    check("clean ready", 32'(ready), 1);
    check("clean sys_rst", 32'(sys_rst), 0);
    check("clean retry", 32'(retry_count), 0);

    // Timeout retry: first attempt times out, second locks.
    apply_reset();
    ticks(23);
    check("retry still waiting", 32'(state), 1);
    tick();
    check("retry back to reset_pll", 32'(state), 0);
    check("retry count 1", 32'(retry_count), 1);
    pll_locked = 1'b1;
    pulse_len(plen);
    check("retry pll_rst pulse len", 32'(plen), 4);
    wait_state(3'd3, 100, "retry reaches run");
    check("retry cleared in run", 32'(retry_count), 0);

    // Fault after two failed attempts; pll_locked ignored while latched.
    apply_reset();
    ticks(47);
    check("fault pre state", 32'(state), 1);
    tick();
    check("fault state", 32'(state), 4);
    check("fault flag", 32'(fault), 1);
    check("fault pll_rst", 32'(pll_rst), 1);
    check("fault sys_rst", 32'(sys_rst), 1);
    check("fault retry", 32'(retry_count), 2);
    for (int i = 0; i < 200; i++) begin
      pll_locked = 1'($urandom_range(0, 1));
      tick();
    end
    check("fault held", 32'(state), 4);
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
    check("soft exit state", 32'(state), 0);
    check("soft exit fault", 32'(fault), 0);
    check("soft exit retry", 32'(retry_count), 0);

    // Stability glitch: one low cycle during STABLE restarts qualification.
    pll_locked = 1'b1;
    wait_state(3'd2, 100, "glitch reach stable");
    ticks(2);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    ticks(2);
    check("glitch back to wait", 32'(state), 1);
    ticks(8);
    check("glitch not ready early", 32'(ready), 0);
    tick();
    check("glitch ready after fresh 8", 32'(ready), 1);

    // Lock loss in RUN.
    pll_locked = 1'b0;
    ticks(2);
    check("loss sys_rst not yet", 32'(sys_rst), 0);
    tick();
    check("loss sys_rst within 3", 32'(sys_rst), 1);
    check("loss ready", 32'(ready), 0);
    check("loss relock 1", 32'(relock_count), 1);
    pulse_len(plen);
    check("loss pll_rst pulse len", 32'(plen), 4);
    for (int i = 0; i < 259; i++) begin
      pll_locked = 1'b1;
      wait_state(3'd3, 100, "relock reach run");
      pll_locked = 1'b0;
      wait_state(3'd0, 10, "relock drop");
    end
    check("relock saturated", 32'(relock_count), 255);

    // Async reset mid-STABLE takes effect immediately.
    pll_locked = 1'b1;
    wait_state(3'd2, 100, "async reach stable");
    ticks(3);
    rst = 1'b1;
    #1;
    check("async state", 32'(state), 0);
    check("async pll_rst", 32'(pll_rst), 1);
    check("async sys_rst", 32'(sys_rst), 1);
    check("async relock", 32'(relock_count), 0);
    tick();
    rst = 1'b0;

    // Soft request on the same edge as a RUN lock loss.
    wait_state(3'd3, 100, "prio reach run 1");
    pll_locked = 1'b0;
    wait_state(3'd0, 10, "prio first loss");
    pll_locked = 1'b1;
    wait_state(3'd3, 100, "prio reach run 2");
    pll_locked = 1'b0;
    ticks(2);
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
    check("prio state", 32'(state), 0);
    check("prio relock unchanged", 32'(relock_count), 1);
    check("prio sys_rst", 32'(sys_rst), 1);

    // Randomized phase.
    for (int cyc = 0; cyc < 3000;) begin
      int hold;
      pll_locked = ($urandom_range(0, 3) != 0);
      hold = $urandom_range(1, 30);
      for (int j = 0; j < hold; j++) begin
        soft_reset_req = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 999) == 0) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
        end
        tick();
        cyc++;
      end
    end
    soft_reset_req = 1'b0;
    ticks(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
